// File: rtl/uart_tx_corr_1.sv
// UART transmitter with an AXI-Stream style input: start bit, LSB-first data, one stop bit.
// Each bit lasts prescale*8 clocks, using the prescale value captured when the word is accepted.
module uart_tx_corr_1 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic                  txd,
  output logic                  busy,
  input  logic [15:0]           prescale
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t                state;
  logic [18:0]           bit_cyc;
  logic [18:0]           cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [IDX_W-1:0]      bit_idx;

  logic [15:0]           pres_eff;
  logic [18:0]           bit_cyc_in;
  logic                  cnt_done;

  // A prescale of 0 behaves as 1. The 19-bit width holds 16'hFFFF * 8 without overflow.
  assign pres_eff   = (prescale == 16'd0) ? 16'd1 : prescale;
  assign bit_cyc_in = {pres_eff, 3'b000};
  assign cnt_done   = (cnt == 19'd0);

  // The counter is loaded with BITCYC-1 at the start of each bit.
  // The bit then ends on the edge where the counter reads zero, which makes it exactly BITCYC cycles long.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      txd           <= 1'b1;
      s_axis_tready <= 1'b0;
      busy          <= 1'b0;
      cnt           <= '0;
      bit_cyc       <= '0;
      shreg         <= '0;
      bit_idx       <= '0;
    end else begin
      case (state)
        IDLE: begin
          txd           <= 1'b1;
          busy          <= 1'b0;
          s_axis_tready <= 1'b1;
          if (s_axis_tvalid && s_axis_tready) begin
            shreg         <= s_axis_tdata;
            bit_cyc       <= bit_cyc_in;
            cnt           <= bit_cyc_in - 19'd1;
            state         <= START;
            txd           <= 1'b0;
            s_axis_tready <= 1'b0;
            busy          <= 1'b1;
          end
        end
        START: begin
          if (cnt_done) begin
            state   <= DATA;
            txd     <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= '0;
            cnt     <= bit_cyc - 19'd1;
          end else begin
            cnt <= cnt - 19'd1;
          end
        end
        DATA: begin
          if (cnt_done) begin
            cnt <= bit_cyc - 19'd1;
            if (bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
              state <= STOP;
              txd   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              txd     <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else begin
            cnt <= cnt - 19'd1;
          end
        end
        STOP: begin
          if (cnt_done) begin
            state         <= IDLE;
            txd           <= 1'b1;
            s_axis_tready <= 1'b1;
            busy          <= 1'b0;
          end else begin
            cnt <= cnt - 19'd1;
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_corr_1.sv
// Directed bench for uart_tx_corr_1: checks txd, busy and s_axis_tready on every cycle of each frame.
// Outputs are sampled on the falling edge, while inputs change at the falling edge.
module tb_uart_tx_corr_1;

  logic        clk;
  logic        rst;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        txd;
  logic        busy;
  logic [15:0] prescale;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  uart_tx_corr_1 #(.DATA_WIDTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .txd           (txd),
    .busy          (busy),
    .prescale      (prescale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge while the transmitter is idle.
  // On return it is the falling edge after the acceptance edge, which is cycle 0 of the frame.
  task automatic applyStimulus(input logic [7:0] data, input logic [15:0] pres, input bit keep_valid);
    s_axis_tdata  = data;
    prescale      = pres;
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    if (!keep_valid) s_axis_tvalid = 1'b0;
  endtask

  // kind 1: at cycle event_j, change tdata and prescale and raise tvalid.
  // kind 2: at cycle event_j, assert rst and return.
  task automatic runFrame(input logic [7:0] data, input int bitcyc, input int event_j,
                          input int kind, input logic [7:0] nxt_data, input logic [15:0] nxt_pres);
    logic [9:0] frame;
    frame = {1'b1, data, 1'b0};
    for (int j = 0; j < 10 * bitcyc; j++) begin
      checkOutput(32'(txd), 32'(frame[j / bitcyc]), $sformatf("frame_%h_txd_c%0d", data, j));
      checkOutput(32'(busy), 32'd1, $sformatf("frame_%h_busy_c%0d", data, j));
      checkOutput(32'(s_axis_tready), 32'd0, $sformatf("frame_%h_tready_c%0d", data, j));
      if (j == event_j) begin
        if (kind == 2) begin
          rst = 1'b1;
          return;
        end else if (kind == 1) begin
          s_axis_tdata  = nxt_data;
          prescale      = nxt_pres;
          s_axis_tvalid = 1'b1;
        end
      end
      @(negedge clk);
    end
    checkOutput(32'(txd), 32'd1, $sformatf("frame_%h_idle_txd", data));
    checkOutput(32'(busy), 32'd0, $sformatf("frame_%h_idle_busy", data));
    checkOutput(32'(s_axis_tready), 32'd1, $sformatf("frame_%h_idle_tready", data));
  endtask

  initial begin
    rst           = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 8'h00;
    prescale      = 16'd6;
    repeat (2) @(negedge clk);
    checkOutput(32'(txd), 32'd1, "reset_txd");
    checkOutput(32'(s_axis_tready), 32'd0, "reset_tready");
    checkOutput(32'(busy), 32'd0, "reset_busy");

    rst = 1'b0;
    @(negedge clk);
    checkOutput(32'(s_axis_tready), 32'd1, "release_tready");
    checkOutput(32'(busy), 32'd0, "release_busy");
    checkOutput(32'(txd), 32'd1, "release_txd");

    $display("[TB] prescale=6, 8'h55");
    applyStimulus(8'h55, 16'd6, 1'b0);
    runFrame(8'h55, 48, -1, 0, 8'h00, 16'd0);

    $display("[TB] back-to-back 8'hA3 then 8'h5C at prescale=1");
    applyStimulus(8'hA3, 16'd1, 1'b1);
    runFrame(8'hA3, 8, 0, 1, 8'h5C, 16'd1);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    runFrame(8'h5C, 8, -1, 0, 8'h00, 16'd0);

    $display("[TB] mid-frame change of prescale and tdata");
    applyStimulus(8'hC5, 16'd6, 1'b0);
    runFrame(8'hC5, 48, 100, 1, 8'h3A, 16'd2);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    runFrame(8'h3A, 16, -1, 0, 8'h00, 16'd0);

    $display("[TB] reset during data bit 3");
    @(negedge clk);
    applyStimulus(8'h96, 16'd1, 1'b0);
    runFrame(8'h96, 8, 34, 2, 8'h00, 16'd0);
    @(negedge clk);
    checkOutput(32'(txd), 32'd1, "abort_txd");
    checkOutput(32'(busy), 32'd0, "abort_busy");
    checkOutput(32'(s_axis_tready), 32'd0, "abort_tready");
    rst = 1'b0;
    @(negedge clk);
    checkOutput(32'(s_axis_tready), 32'd1, "abort_release_tready");
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checkOutput(32'(txd), 32'd1, $sformatf("abort_quiet_txd_c%0d", k));
      checkOutput(32'(busy), 32'd0, $sformatf("abort_quiet_busy_c%0d", k));
    end
    applyStimulus(8'h3C, 16'd1, 1'b0);
    runFrame(8'h3C, 8, -1, 0, 8'h00, 16'd0);

    $display("[TB] prescale=0 treated as 1, 8'hFF");
    @(negedge clk);
    applyStimulus(8'hFF, 16'd0, 1'b0);
    runFrame(8'hFF, 8, -1, 0, 8'h00, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
